// File: rtl/fifo9_tx_arbiter.sv
// fifo9_tx_arbiter
// Round-robin merge of NPORTS 9-bit frame FIFOs (bit8=1 frame byte, bit8=0
// end marker) into one FWFT-style stream for the GMII transmit formatter.
// Frames are kept contiguous. After each end marker the stream is held empty
// for GAP_CYCLES cycles to cover FCS and the inter-frame gap. Source underruns
// are cleaned up by flushing the rest of the frame.
// Optional build macro: ARB_MAXLEN_EN enables truncation of frames longer than
// MAX_LEN bytes. The arbiter presents a synthetic 9'h000 marker and then
// flushes the remainder of the frame.
module fifo9_tx_arbiter #(
    parameter int NPORTS     = 2,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_LEN    = 1514
) (
    input  logic                  gmii_tx_clk,
    input  logic                  sys_rst,
    input  logic [9*NPORTS-1:0]   in_dout,
    input  logic [NPORTS-1:0]     in_empty,
    output logic [NPORTS-1:0]     in_rd_en,
    output logic [8:0]            out_dout,
    output logic                  out_empty,
    input  logic                  out_rd_en,
    output logic [NPORTS-1:0]     grant,
    output logic                  underrun,
    output logic                  maxlen_err
);

    localparam int IW = $clog2(NPORTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_FLUSH = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [7:0]      gap_q, gap_d;

    logic [8:0]      head [NPORTS];
    logic [NPORTS-1:0] stray;
    logic [NPORTS-1:0] req;
    logic [8:0]      ghead;
    logic            gempty;
    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   rr_idx;
    logic            at_max;

    // Split the flat head bus and classify each source's head word.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            head[i]  = in_dout[9*i +: 9];
            stray[i] = ~in_empty[i] & ~in_dout[9*i+8];
            req[i]   = ~in_empty[i] &  in_dout[9*i+8];
        end
    end

    assign ghead  = head[gidx_q];
    assign gempty = in_empty[gidx_q];

    // Round-robin pick: first requesting port after the previous winner.
    always_comb begin
        found  = 1'b0;
        win    = last_q;
        rr_idx = last_q;
        for (int k = 0; k < NPORTS; k++) begin
            rr_idx = (rr_idx == IW'(NPORTS - 1)) ? '0 : rr_idx + 1'b1;
            if (!found && req[rr_idx]) begin
                found = 1'b1;
                win   = rr_idx;
            end
        end
    end

`ifdef ARB_MAXLEN_EN
    logic [15:0] len_q, len_d;

    // Count frame bytes actually consumed by the downstream; cleared while idle.
    always_comb begin
        len_d = len_q;
        if (state_q == S_IDLE) begin
            len_d = '0;
        end else if (state_q == S_FWD && in_rd_en[gidx_q] && ghead[8]) begin
            len_d = len_q + 16'd1;
        end
    end

    // Byte counter register.
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    // A real marker at exactly MAX_LEN bytes wins because the head must still be a byte.
    assign at_max = (len_q == 16'(MAX_LEN)) && !gempty && ghead[8];
`else
    // MAX_LEN only matters when truncation is built in.
    localparam int unused_max_len = MAX_LEN;
    assign at_max = 1'b0;
`endif

    // Next-state and all stream/handshake outputs; pass-through is combinational.
    always_comb begin
        state_d    = state_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        gap_d      = gap_q;
        in_rd_en   = '0;
        out_dout   = 9'h000;
        out_empty  = 1'b1;
        grant      = '0;
        underrun   = 1'b0;
        maxlen_err = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Stray markers are discarded in the same cycle as arbitration.
                in_rd_en = stray;
                if (found) begin
                    gidx_d  = win;
                    last_d  = win;
                    state_d = S_FWD;
                end
            end

            S_FWD: begin
                grant[gidx_q] = 1'b1;
                out_dout      = ghead;
                out_empty     = gempty;
                if (gempty) begin
                    underrun = 1'b1;
                    state_d  = S_FLUSH;
                end else if (at_max) begin
                    out_dout  = 9'h000;
                    out_empty = 1'b0;
                    if (out_rd_en) begin
                        maxlen_err = 1'b1;
                        state_d    = S_FLUSH;
                    end
                end else begin
                    in_rd_en[gidx_q] = out_rd_en;
                    if (out_rd_en && !ghead[8]) begin
                        gap_d   = 8'(GAP_CYCLES);
                        state_d = S_GAP;
                    end
                end
            end

            S_FLUSH: begin
                grant[gidx_q]    = 1'b1;
                in_rd_en[gidx_q] = ~gempty;
                if (!gempty && !ghead[8]) begin
                    gap_d   = 8'(GAP_CYCLES);
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Nothing is popped while reset is held, even if a stray marker is waiting.
        if (sys_rst) begin
            in_rd_en = '0;
        end
    end

    // Control registers; port 0 gets first priority after reset.
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            last_q  <= IW'(NPORTS - 1);
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_fifo9_tx_arbiter.sv
`timescale 1ns/1ps
// Directed bench for fifo9_tx_arbiter with two modelled FWFT source FIFOs.
module tb_fifo9_tx_arbiter;

    localparam int NP   = 2;
    localparam int GAP  = 16;
    localparam int MAXL = 64;
    localparam logic [8:0] MARK = 9'h0EE;

    logic            clk = 1'b0;
    logic            rst;
    logic [9*NP-1:0] in_dout;
    logic [NP-1:0]   in_empty;
    logic [NP-1:0]   in_rd_en;
    logic [8:0]      out_dout;
    logic            out_empty;
    logic            out_rd_en;
    logic [NP-1:0]   grant;
    logic            underrun;
    logic            maxlen_err;

    fifo9_tx_arbiter #(.NPORTS(NP), .GAP_CYCLES(GAP), .MAX_LEN(MAXL)) dut (
        .gmii_tx_clk (clk),
        .sys_rst     (rst),
        .in_dout     (in_dout),
        .in_empty    (in_empty),
        .in_rd_en    (in_rd_en),
        .out_dout    (out_dout),
        .out_empty   (out_empty),
        .out_rd_en   (out_rd_en),
        .grant       (grant),
        .underrun    (underrun),
        .maxlen_err  (maxlen_err)
    );

    always #5 clk = ~clk;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] outq[$];
    logic [8:0] expq[$];

    int n_cmp = 0;
    int n_fail = 0;
    int n_und, n_mle, pops0, pops1, cyc, bad_pop;
    logic            s_empty;
    logic [NP-1:0]   s_grant;
    logic [NP-1:0]   s_rd;
    logic [8:0]      s_dout;
    logic [8:0]      last_pop;
    logic [NP-1:0]   hist_grant [512];
    logic            hist_empty [512];
    logic [8:0]      hist_dout  [512];

    task automatic drive();
        in_empty[0]   = (q0.size() == 0);
        in_empty[1]   = (q1.size() == 0);
        in_dout[8:0]  = (q0.size() != 0) ? q0[0] : 9'h000;
        in_dout[17:9] = (q1.size() != 0) ? q1[0] : 9'h000;
    endtask

    task automatic clear_stats();
        outq.delete();
        expq.delete();
        n_und = 0; n_mle = 0; pops0 = 0; pops1 = 0; cyc = 0;
    endtask

    task automatic push_bytes(input int port, input int base, input int n, input bit exp_out);
        logic [8:0] w;
        for (int i = 0; i < n; i++) begin
            w = {1'b1, 8'(base + i)};
            if (port == 0) q0.push_back(w); else q1.push_back(w);
            if (exp_out) expq.push_back(w);
        end
    endtask

    task automatic push_mark(input int port, input bit exp_out);
        if (port == 0) q0.push_back(MARK); else q1.push_back(MARK);
        if (exp_out) expq.push_back(MARK);
    endtask

    // One clock: sample stable outputs at negedge, apply source pops after posedge.
    task automatic step();
        @(negedge clk);
        s_empty = out_empty; s_grant = grant; s_rd = in_rd_en; s_dout = out_dout;
        if (cyc < 512) begin
            hist_grant[cyc] = grant; hist_empty[cyc] = out_empty; hist_dout[cyc] = out_dout;
        end
        cyc++;
        if (out_rd_en && !out_empty) outq.push_back(out_dout);
        if (underrun) n_und++;
        if (maxlen_err) n_mle++;
        @(posedge clk);
        #1;
        if (s_rd[0]) begin
            if (q0.size() != 0) begin last_pop = q0.pop_front(); pops0++; end else bad_pop++;
        end
        if (s_rd[1]) begin
            if (q1.size() != 0) begin last_pop = q1.pop_front(); pops1++; end else bad_pop++;
        end
        drive();
    endtask

    function automatic int first_diff();
        int n;
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++) if (outq[i] !== expq[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; out_rd_en = 1'b1; bad_pop = 0; last_pop = '0;
        q1.push_back(9'h055);
        drive();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", out_empty); end
        n_cmp++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", grant); end
        n_cmp++; if (in_rd_en !== 2'b00) begin n_fail++; $display("FAIL rst_rd_en: got %b want 00", in_rd_en); end
        n_cmp++; if (out_dout !== 9'h000) begin n_fail++; $display("FAIL rst_dout: got %h want 000", out_dout); end
        n_cmp++; if ({underrun, maxlen_err} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b want 00", {underrun, maxlen_err}); end
        q1.delete();
        drive();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_two_ports();
        int tm, tf, nz, d;
        clear_stats();
        push_bytes(0, 8'h00, 60, 1); push_mark(0, 1);
        push_bytes(1, 8'h80, 60, 1); push_mark(1, 1);
        drive();
        for (int i = 0; i < 200; i++) step();
        n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL two_len: got %0d words want %0d", outq.size(), expq.size()); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL two_data: word %0d got %h want %h", d, outq[d], expq[d]); end
        n_cmp++; if (pops0 != 61 || pops1 != 61) begin n_fail++; $display("FAIL two_pops: got %0d/%0d want 61/61", pops0, pops1); end
        tm = -1;
        for (int i = 0; i < 200; i++) if (tm < 0 && !hist_empty[i] && !hist_dout[i][8]) tm = i;
        n_cmp++; if (tm != 60) begin n_fail++; $display("FAIL two_mark_cyc: got %0d want 60", tm); end
        tf = -1;
        for (int i = 61; i < 200; i++) if (tf < 0 && !hist_empty[i]) tf = i;
        // 16 gap cycles plus one arbitration cycle before port 1's first byte.
        n_cmp++; if (tf != 60 + GAP + 2) begin n_fail++; $display("FAIL two_gap: got %0d want %0d", tf, 60 + GAP + 2); end
        n_cmp++; if (hist_grant[1] !== 2'b01) begin n_fail++; $display("FAIL two_grant0: got %b want 01", hist_grant[1]); end
        n_cmp++; if (hist_grant[78] !== 2'b10) begin n_fail++; $display("FAIL two_grant1: got %b want 10", hist_grant[78]); end
        nz = 0;
        for (int i = 61; i < 78; i++) if (hist_grant[i] != 2'b00) nz++;
        n_cmp++; if (nz != 0) begin n_fail++; $display("FAIL two_gap_grant: got %0d granted cycles want 0", nz); end
        n_cmp++; if (n_mle != 0 || n_und != 0) begin n_fail++; $display("FAIL two_pulses: got und=%0d mle=%0d want 0/0", n_und, n_mle); end
    endtask

    task automatic test_stray();
        clear_stats();
        q1.push_back(9'h0AB);
        drive();
        step();
        n_cmp++; if (s_rd !== 2'b10) begin n_fail++; $display("FAIL stray_rd: got %b want 10", s_rd); end
        n_cmp++; if (s_grant !== 2'b00 || s_empty !== 1'b1) begin n_fail++; $display("FAIL stray_out: got grant=%b empty=%b want 00/1", s_grant, s_empty); end
        step();
        n_cmp++; if (q1.size() != 0 || pops1 != 1) begin n_fail++; $display("FAIL stray_pop: got left=%0d pops=%0d want 0/1", q1.size(), pops1); end
        n_cmp++; if (s_grant !== 2'b00 || s_empty !== 1'b1 || s_rd !== 2'b00) begin n_fail++; $display("FAIL stray_after: got grant=%b empty=%b rd=%b want 00/1/00", s_grant, s_empty, s_rd); end
    endtask

    task automatic test_underrun();
        int t, k, d;
        clear_stats();
        push_bytes(0, 8'h40, 20, 1);
        drive();
        t = 0;
        while (q0.size() != 0 && t < 60) begin step(); t++; end
        n_cmp++; if (q0.size() != 0) begin n_fail++; $display("FAIL und_first: got %0d left want 0", q0.size()); end
        repeat (5) step();
        n_cmp++; if (n_und != 1) begin n_fail++; $display("FAIL und_pulse: got %0d pulses want 1", n_und); end
        n_cmp++; if (s_grant !== 2'b01 || s_rd !== 2'b00 || s_empty !== 1'b1) begin n_fail++; $display("FAIL und_hold: got grant=%b rd=%b empty=%b want 01/00/1", s_grant, s_rd, s_empty); end
        push_bytes(0, 8'h40 + 20, 44, 0); push_mark(0, 0);
        drive();
        t = 0;
        while (q0.size() != 0 && t < 100) begin step(); t++; end
        n_cmp++; if (q0.size() != 0 || pops0 != 65) begin n_fail++; $display("FAIL und_flush: got left=%0d pops=%0d want 0/65", q0.size(), pops0); end
        push_bytes(1, 8'hC0, 2, 1); push_mark(1, 1);
        drive();
        k = 0;
        s_empty = 1'b1;
        while (s_empty && k < 40) begin step(); k++; end
        n_cmp++; if (k != GAP + 2) begin n_fail++; $display("FAIL und_gap: got %0d cycles want %0d", k, GAP + 2); end
        repeat (30) step();
        n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL und_len: got %0d words want %0d", outq.size(), expq.size()); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL und_data: word %0d got %h want %h", d, outq[d], expq[d]); end
    endtask

    task automatic test_back_to_back();
        int rises, zeros, d;
        clear_stats();
        for (int f = 0; f < 3; f++) begin
            push_bytes(0, 64 * f, 64, 1); push_mark(0, 1);
        end
        drive();
        for (int i = 0; i < 300; i++) step();
        n_cmp++; if (outq.size() != 195) begin n_fail++; $display("FAIL b2b_len: got %0d words want 195", outq.size()); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL b2b_data: word %0d got %h want %h", d, outq[d], expq[d]); end
        n_cmp++; if (pops0 != 195) begin n_fail++; $display("FAIL b2b_pops: got %0d want 195", pops0); end
        rises = 0; zeros = 0;
        for (int i = 1; i < 300; i++) if (hist_grant[i][0] && !hist_grant[i-1][0]) rises++;
        for (int i = 1; i < 230; i++) if (hist_grant[i] == 2'b00) zeros++;
        n_cmp++; if (rises != 3) begin n_fail++; $display("FAIL b2b_grants: got %0d grants want 3", rises); end
        n_cmp++; if (zeros != 2 * (GAP + 1)) begin n_fail++; $display("FAIL b2b_gaps: got %0d idle cycles want %0d", zeros, 2 * (GAP + 1)); end
    endtask

    task automatic test_reset_midframe();
        int t;
        clear_stats();
        push_bytes(0, 8'h10, 64, 0); push_mark(0, 0);
        drive();
        t = 0;
        while (outq.size() < 30 && t < 60) begin step(); t++; end
        n_cmp++; if (outq.size() != 30) begin n_fail++; $display("FAIL mrst_reach: got %0d words want 30", outq.size()); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_empty !== 1'b1 || in_rd_en !== 2'b00 || grant !== 2'b00) begin n_fail++; $display("FAIL mrst_now: got empty=%b rd=%b grant=%b want 1/00/00", out_empty, in_rd_en, grant); end
        @(negedge clk);
        rst = 1'b0;
        q0.delete(); q1.delete();
        clear_stats();
        push_bytes(0, 8'h20, 3, 1); push_mark(0, 1);
        push_bytes(1, 8'hA0, 3, 1); push_mark(1, 1);
        drive();
        step();
        step();
        n_cmp++; if (s_grant !== 2'b01) begin n_fail++; $display("FAIL mrst_prio: got %b want 01", s_grant); end
        repeat (40) step();
        n_cmp++; if (outq.size() != 8 || first_diff() != -1) begin n_fail++; $display("FAIL mrst_stream: got %0d words diff@%0d want 8 words in order", outq.size(), first_diff()); end
    endtask

`ifdef ARB_MAXLEN_EN
    task automatic test_maxlen();
        int d;
        clear_stats();
        push_bytes(0, 8'h00, 100, 0); push_mark(0, 0);
        for (int i = 0; i < 64; i++) expq.push_back({1'b1, 8'(i)});
        expq.push_back(9'h000);
        drive();
        for (int i = 0; i < 200; i++) step();
        n_cmp++; if (outq.size() != 65) begin n_fail++; $display("FAIL ml_len: got %0d words want 65", outq.size()); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL ml_data: word %0d got %h want %h", d, outq[d], expq[d]); end
        n_cmp++; if (n_mle != 1 || n_und != 0) begin n_fail++; $display("FAIL ml_pulse: got mle=%0d und=%0d want 1/0", n_mle, n_und); end
        n_cmp++; if (pops0 != 101) begin n_fail++; $display("FAIL ml_pops: got %0d want 101", pops0); end
        n_cmp++; if (hist_dout[65] !== 9'h000 || hist_empty[65] !== 1'b0) begin n_fail++; $display("FAIL ml_synth: got dout=%h empty=%b want 000/0", hist_dout[65], hist_empty[65]); end
    endtask
`else
    task automatic test_maxlen();
        int d;
        clear_stats();
        push_bytes(0, 8'h00, 100, 1); push_mark(0, 1);
        drive();
        for (int i = 0; i < 200; i++) step();
        n_cmp++; if (outq.size() != 101) begin n_fail++; $display("FAIL noml_len: got %0d words want 101", outq.size()); end
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL noml_data: word %0d got %h want %h", d, outq[d], expq[d]); end
        n_cmp++; if (n_mle != 0) begin n_fail++; $display("FAIL noml_pulse: got %0d pulses want 0", n_mle); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_ports();
        test_stray();
        test_underrun();
        test_back_to_back();
        test_reset_midframe();
        test_maxlen();
        n_cmp++; if (bad_pop != 0) begin n_fail++; $display("FAIL empty_pops: got %0d pops of empty sources want 0", bad_pop); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
